// File: rtl/fft8_pkg.sv
// Shared constants and helpers for the 8-point FFT datapath: twiddle indices,
// the 1/sqrt2 shift list and signed saturation.
package fft8_pkg;

  // Shift amounts whose sum of 2^-n terms approximates 1/sqrt2 (181/256)
  localparam int SHIFT_LIST [5] = '{1, 3, 4, 6, 8};

  localparam logic [2:0] TW_0 = 3'd0;
  localparam logic [2:0] TW_1 = 3'd1;
  localparam logic [2:0] TW_2 = 3'd2;
  localparam logic [2:0] TW_3 = 3'd3;
  localparam logic [2:0] TW_4 = 3'd4;
  localparam logic [2:0] TW_5 = 3'd5;
  localparam logic [2:0] TW_6 = 3'd6;
  localparam logic [2:0] TW_7 = 3'd7;

  function automatic logic signed [31:0] sat_w(input logic signed [31:0] value,
                                               input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/inv_sqrt2_scale.sv
// Two-stage registered shift-add multiply by 181/256 (about 1/sqrt2).
// TWIDDLE_ROUND_EN: exact x*181 with round-half-up; otherwise each term floored.
module inv_sqrt2_scale
  import fft8_pkg::*;
#(
  parameter int XW = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [XW-1:0] x,
  output logic signed [XW-1:0] y
);

`ifdef TWIDDLE_ROUND_EN
  localparam int FRAC = 8;
`else
  localparam int FRAC = 0;
`endif
  localparam int PW = XW + FRAC + 1;

  logic signed [XW-1:0] x_p1_d, x_p1_q;
  logic signed [PW-1:0] xa;
  logic signed [PW-1:0] pa_p2_d, pa_p2_q;
  logic signed [PW-1:0] pb_p2_d, pb_p2_q;
  logic signed [PW-1:0] pc_p2_d, pc_p2_q;
  logic signed [PW-1:0] sum;

  always_comb begin
    x_p1_d  = x;
    // Left-aligning by FRAC bits makes every shifted term exact in rounding mode
    xa      = PW'(x_p1_q) <<< FRAC;
    pa_p2_d = (xa >>> SHIFT_LIST[0]) + (xa >>> SHIFT_LIST[1]);
    pb_p2_d = (xa >>> SHIFT_LIST[2]) + (xa >>> SHIFT_LIST[3]);
    pc_p2_d = xa >>> SHIFT_LIST[4];
    sum     = pa_p2_q + pb_p2_q + pc_p2_q;
`ifdef TWIDDLE_ROUND_EN
    y       = XW'((sum + (PW'(1) <<< (FRAC - 1))) >>> FRAC);
`else
    y       = XW'(sum);
`endif
  end

  // stage 1: operand register
  // stage 2: partial sums
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_p1_q  <= '0;
      pa_p2_q <= '0;
      pb_p2_q <= '0;
      pc_p2_q <= '0;
    end else if (en) begin
      x_p1_q  <= x_p1_d;
      pa_p2_q <= pa_p2_d;
      pb_p2_q <= pb_p2_d;
      pc_p2_q <= pc_p2_d;
    end
  end

endmodule

// File: rtl/twiddle_mul_w8.sv
// Pipelined complex multiply by W8^k (3-cycle latency, stallable via en).
// TWIDDLE_ROUND_EN selects round-half-up in the 1/sqrt2 scaler.
module twiddle_mul_w8
  import fft8_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [2:0]          in_k,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  output logic                out_valid,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im
);

  // Two guard bits: one for a+b, one so that -(a+b) never wraps
  localparam int XW = W + 2;

  logic signed [XW-1:0] a_x, b_x, s_x, d_x;
  logic signed [XW-1:0] op_re_p1_d, op_im_p1_d, op_re_p1_q, op_im_p1_q;
  logic signed [XW-1:0] op_re_p2_q, op_im_p2_q;
  logic                 odd_p1_d, odd_p1_q, odd_p2_q;
  logic                 vld_p1_q, vld_p2_q;
  logic signed [XW-1:0] sc_re, sc_im;
  logic signed [XW-1:0] res_re, res_im;
  logic signed [W-1:0]  out_re_d, out_re_q, out_im_d, out_im_q;
  logic                 out_valid_q;

  // stage 1: pre-add and operand select; signs are folded in before scaling
  always_comb begin
    a_x        = XW'(in_re);
    b_x        = XW'(in_im);
    s_x        = a_x + b_x;
    d_x        = a_x - b_x;
    odd_p1_d   = in_k[0];
    op_re_p1_d = a_x;
    op_im_p1_d = b_x;
    case (in_k)
      TW_0: begin op_re_p1_d =  a_x; op_im_p1_d =  b_x; end
      TW_1: begin op_re_p1_d =  s_x; op_im_p1_d = -d_x; end
      TW_2: begin op_re_p1_d =  b_x; op_im_p1_d = -a_x; end
      TW_3: begin op_re_p1_d = -d_x; op_im_p1_d = -s_x; end
      TW_4: begin op_re_p1_d = -a_x; op_im_p1_d = -b_x; end
      TW_5: begin op_re_p1_d = -s_x; op_im_p1_d =  d_x; end
      TW_6: begin op_re_p1_d = -b_x; op_im_p1_d =  a_x; end
      TW_7: begin op_re_p1_d =  d_x; op_im_p1_d =  s_x; end
      default: ;
    endcase
  end

  inv_sqrt2_scale #(.XW(XW)) u_scale_re (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .x   (op_re_p1_d),
    .y   (sc_re)
  );

  inv_sqrt2_scale #(.XW(XW)) u_scale_im (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .x   (op_im_p1_d),
    .y   (sc_im)
  );

  // stage 3: pick scaled or bypass rail, saturate to W bits
  always_comb begin
    res_re   = odd_p2_q ? sc_re : op_re_p2_q;
    res_im   = odd_p2_q ? sc_im : op_im_p2_q;
    out_re_d = W'(sat_w(32'(res_re), W));
    out_im_d = W'(sat_w(32'(res_im), W));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q    <= 1'b0;
      odd_p1_q    <= 1'b0;
      op_re_p1_q  <= '0;
      op_im_p1_q  <= '0;
      vld_p2_q    <= 1'b0;
      odd_p2_q    <= 1'b0;
      op_re_p2_q  <= '0;
      op_im_p2_q  <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else if (en) begin
      vld_p1_q    <= in_valid;
      odd_p1_q    <= odd_p1_d;
      op_re_p1_q  <= op_re_p1_d;
      op_im_p1_q  <= op_im_p1_d;
      vld_p2_q    <= vld_p1_q;
      odd_p2_q    <= odd_p1_q;
      op_re_p2_q  <= op_re_p1_q;
      op_im_p2_q  <= op_im_p1_q;
      out_valid_q <= vld_p2_q;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule
